n1_sbus_ram: RTL and testbench
==============================

// Module: N1_sbus_ram
// PURPOSE
//  Stack bus responder: single-port stack RAM serving the pipelined Wishbone stack bus driven by the N1 SAGU/PRS.
//  Accepts tagged PS/RS cell accesses at absolute SP_WIDTH addresses, with programmable wait states and
//  error response on illegal tags. Sits at the far end of sbus, outside the N1 core (FPGA block RAM or simulation).
// PARAMETERS
//  SP_WIDTH     12  address width; RAM depth is 2**SP_WIDTH cells
//  CELL_WIDTH   16  data width of one stack cell
//  WAIT_STATES   0  extra cycles between accept and ack (0..15)
// PORTS
//  clk_i           in   1           system clock, all logic on rising edge
//  async_rst_i     in   1           asynchronous reset, active-low
//  sbus_cyc_i      in   1           bus cycle indicator
//  sbus_stb_i      in   1           access request
//  sbus_we_i       in   1           1:write, 0:read
//  sbus_adr_i      in   SP_WIDTH    cell address
//  sbus_tga_ps_i   in   1           parameter stack access
//  sbus_tga_rs_i   in   1           return stack access
//  sbus_dat_i      in   CELL_WIDTH  write data
//  sbus_ack_o      out  1           access acknowledge
//  sbus_err_o      out  1           access error (illegal tag)
//  sbus_stall_o    out  1           responder busy, request not accepted
//  sbus_dat_o      out  CELL_WIDTH  read data
// BEHAVIOUR
//  Reset (async_rst_i low): state IDLE, wait counter 0, ack/err/stall 0, dat_o 0. RAM contents not reset.
//  Accept: cyc_i & stb_i & ~stall_o on a rising edge. Address, we, tag, dat_i captured only at accept.
//  Tag legal iff exactly one of tga_ps_i/tga_rs_i set; illegal tag -> response is err, RAM untouched.
//  Write commits to RAM in the accept cycle; read samples RAM[adr] at accept (read-after-write returns new data).
//  FSM states:
//   IDLE : stall_o=0. Accept & WAIT_STATES==0 -> RESP; accept & WAIT_STATES>0 -> BUSY, cnt=WAIT_STATES-1.
//   BUSY : stall_o=1. cnt>0 -> cnt-1; cnt==0 -> RESP. cyc_i low -> IDLE, no response.
//   RESP : ack_o (legal) or err_o (illegal) high exactly one cycle; stall_o=0; new accept allowed
//          in same cycle (-> RESP or BUSY as in IDLE), else -> IDLE.
//  Latency: accept at edge N -> ack/err high during cycle N+1+WAIT_STATES. WAIT_STATES=0 gives one
//   response per cycle for back-to-back requests (full pipelining, stall_o never asserted).
//  ack_o/err_o never both high; both forced low combinationally while cyc_i low.
//  cyc_i dropped with a response pending: response discarded, FSM -> IDLE; committed write stays.
//  dat_o updated only on legal read responses; holds last read value otherwise (writes, errors, idle).
//  Address wrap: adr_i used modulo 2**SP_WIDTH, no range check (overflow is SAGU's job).
//  stb_i without cyc_i ignored. Reset mid-access aborts; pending write already committed persists.
// TESTING
//  WS=0: write 0xBEEF @0x010 (ps), read @0x010 (ps) next cycle -> ack each cycle, dat_o=0xBEEF at 2nd ack.
//  WS=0: 4 back-to-back reads @0xFFC..0xFFF (rs) after preload -> 4 consecutive acks, stall_o stays 0.
//  WS=3: read @0x123 -> stall_o high 3 cycles, ack in cycle N+4, no 2nd request accepted while stalled.
//  tga_ps=tga_rs=1 write 0x1234 @0x020 -> err_o one cycle, ack_o 0, later read @0x020 unchanged.
//  WS=3: write 0x5555 @0x030, drop cyc_i in BUSY -> no ack/err, FSM IDLE, read @0x030 returns 0x5555.
//  async_rst_i low during BUSY -> ack/err/stall/dat_o 0 immediately; first post-reset access acks normally.

Source files
------------

// File: rtl/n1_sbus_ram.sv
// rtl/n1_sbus_ram.sv - stack bus responder: tagged single-port stack RAM with wait states
module n1_sbus_ram #(
   parameter int SP_WIDTH    = 12,
   parameter int CELL_WIDTH  = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk_i,
   input  logic                  async_rst_i,
   input  logic                  sbus_cyc_i,
   input  logic                  sbus_stb_i,
   input  logic                  sbus_we_i,
   input  logic [SP_WIDTH-1:0]   sbus_adr_i,
   input  logic                  sbus_tga_ps_i,
   input  logic                  sbus_tga_rs_i,
   input  logic [CELL_WIDTH-1:0] sbus_dat_i,
   output logic                  sbus_ack_o,
   output logic                  sbus_err_o,
   output logic                  sbus_stall_o,
   output logic [CELL_WIDTH-1:0] sbus_dat_o
);

   localparam int DEPTH = 1 << SP_WIDTH;
   // Counter preload for the BUSY phase; unused when there are no wait states.
   localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic                  ack_r;
   logic                  err_r;
   logic                  legal_q;
   logic                  we_q;
   logic [CELL_WIDTH-1:0] mem [DEPTH];
   logic [CELL_WIDTH-1:0] rd_hold;
   logic                  accept;
   logic                  legal;

   assign sbus_stall_o = (state == BUSY);
   assign accept       = sbus_cyc_i & sbus_stb_i & ~sbus_stall_o;
   // A legal access names exactly one of the two stacks.
   assign legal        = sbus_tga_ps_i ^ sbus_tga_rs_i;
   // A dropped cycle discards any response that is currently showing.
   assign sbus_ack_o   = ack_r & sbus_cyc_i;
   assign sbus_err_o   = err_r & sbus_cyc_i;

   // RAM port: writes commit and reads sample at accept; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept && async_rst_i) begin
         if (legal && sbus_we_i) begin
            mem[sbus_adr_i] <= sbus_dat_i;
         end
         rd_hold <= mem[sbus_adr_i];
      end
   end

   // Response FSM: IDLE/RESP accept, BUSY counts wait states, RESP shows ack or err for one cycle.
   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
         legal_q    <= 1'b0;
         we_q       <= 1'b0;
         sbus_dat_o <= '0;
      end else begin
         case (state)
            BUSY: begin
               if (!sbus_cyc_i) begin
                  state <= IDLE;
               end else if (cnt == 4'd0) begin
                  state <= RESP;
                  ack_r <= legal_q;
                  err_r <= ~legal_q;
                  if (legal_q && !we_q) begin
                     sbus_dat_o <= rd_hold;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               ack_r <= 1'b0;
               err_r <= 1'b0;
               if (accept) begin
                  legal_q <= legal;
                  we_q    <= sbus_we_i;
                  if (WAIT_STATES == 0) begin
                     state <= RESP;
                     ack_r <= legal;
                     err_r <= ~legal;
                     if (legal && !sbus_we_i) begin
                        sbus_dat_o <= mem[sbus_adr_i];
                     end
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_INIT;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_n1_sbus_ram.sv
// tb/tb_n1_sbus_ram.sv - directed self-checking bench for n1_sbus_ram (zero and three wait states)
module tb_n1_sbus_ram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        a_cyc = 0, a_stb = 0, a_we = 0, a_ps = 0, a_rs = 0;
   logic [11:0] a_adr = '0;
   logic [15:0] a_din = '0;
   logic        a_ack, a_err, a_stall;
   logic [15:0] a_dout;

   logic        b_cyc = 0, b_stb = 0, b_we = 0, b_ps = 0, b_rs = 0;
   logic [11:0] b_adr = '0;
   logic [15:0] b_din = '0;
   logic        b_ack, b_err, b_stall;
   logic [15:0] b_dout;

   int n_cmp = 0;
   int n_mis = 0;

   int   stalls, lat;
   logic ack_seen, err_seen;

   always #5 clk = ~clk;

   n1_sbus_ram #(.SP_WIDTH(12), .CELL_WIDTH(16), .WAIT_STATES(0)) u_dut0 (
      .clk_i(clk), .async_rst_i(rst_n),
      .sbus_cyc_i(a_cyc), .sbus_stb_i(a_stb), .sbus_we_i(a_we), .sbus_adr_i(a_adr),
      .sbus_tga_ps_i(a_ps), .sbus_tga_rs_i(a_rs), .sbus_dat_i(a_din),
      .sbus_ack_o(a_ack), .sbus_err_o(a_err), .sbus_stall_o(a_stall), .sbus_dat_o(a_dout)
   );

   n1_sbus_ram #(.SP_WIDTH(12), .CELL_WIDTH(16), .WAIT_STATES(3)) u_dut3 (
      .clk_i(clk), .async_rst_i(rst_n),
      .sbus_cyc_i(b_cyc), .sbus_stb_i(b_stb), .sbus_we_i(b_we), .sbus_adr_i(b_adr),
      .sbus_tga_ps_i(b_ps), .sbus_tga_rs_i(b_rs), .sbus_dat_i(b_din),
      .sbus_ack_o(b_ack), .sbus_err_o(b_err), .sbus_stall_o(b_stall), .sbus_dat_o(b_dout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one request on the WS=3 port; during the stall a decoy write to 0x200 is held on the bus.
   task automatic b_txn(input logic we, input logic [11:0] adr, input logic [15:0] din,
                        input logic ps, input logic rs,
                        output int n_stall, output int n_lat, output logic got_ack, output logic got_err);
      b_cyc = 1; b_stb = 1; b_we = we; b_adr = adr; b_din = din; b_ps = ps; b_rs = rs;
      tick();
      b_we = 1; b_adr = 12'h200; b_din = 16'hDEAD; b_ps = 1; b_rs = 0;
      n_stall = 0; n_lat = 0; got_ack = 0; got_err = 0;
      for (int i = 0; i < 10; i++) begin
         if (b_ack || b_err) begin
            got_ack = b_ack;
            got_err = b_err;
            n_lat   = i + 1;
            break;
         end
         if (b_stall) n_stall++;
         tick();
      end
      b_stb = 0;
      tick();
      b_cyc = 0;
   endtask

   initial begin
      #12;
      check("rst_a_ack", 32'(a_ack), 0);
      check("rst_a_err", 32'(a_err), 0);
      check("rst_a_stall", 32'(a_stall), 0);
      check("rst_a_dout", 32'(a_dout), 0);
      check("rst_b_stall", 32'(b_stall), 0);
      #5 rst_n = 1;
      tick();

      // WS=0: write then read back the next cycle
      a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 12'h010; a_ps = 1; a_rs = 0; a_din = 16'hBEEF;
      tick();
      check("a_wr_ack", 32'(a_ack), 1);
      check("a_wr_stall", 32'(a_stall), 0);
      check("a_wr_dout_hold", 32'(a_dout), 0);
      a_we = 0;
      tick();
      check("a_rd_ack", 32'(a_ack), 1);
      check("a_rd_dout", 32'(a_dout), 32'hBEEF);

      // WS=0: preload top of memory, then four back-to-back reads
      for (int i = 0; i < 4; i++) begin
         a_we = 1; a_adr = 12'hFFC + 12'(i); a_ps = 0; a_rs = 1; a_din = 16'hA000 + 16'(i);
         tick();
         check("a_pre_ack", 32'(a_ack), 1);
      end
      check("a_pre_dout_hold", 32'(a_dout), 32'hBEEF);
      for (int i = 0; i < 4; i++) begin
         a_we = 0; a_adr = 12'hFFC + 12'(i);
         tick();
         check("a_b2b_ack", 32'(a_ack), 1);
         check("a_b2b_stall", 32'(a_stall), 0);
         check("a_b2b_dout", 32'(a_dout), 32'hA000 + i);
      end

      // WS=0: illegal tags produce err and leave RAM and dat_o alone
      a_we = 1; a_adr = 12'h020; a_ps = 1; a_rs = 0; a_din = 16'h0F0F;
      tick();
      check("a_pre20_ack", 32'(a_ack), 1);
      a_ps = 1; a_rs = 1; a_din = 16'h1234;
      tick();
      check("a_ill_wr_err", 32'(a_err), 1);
      check("a_ill_wr_ack", 32'(a_ack), 0);
      a_we = 0; a_ps = 0; a_rs = 0;
      tick();
      check("a_ill_rd_err", 32'(a_err), 1);
      check("a_ill_rd_dout", 32'(a_dout), 32'hA003);
      a_cyc = 0; a_stb = 0;
      #1;
      check("a_err_cyc_low", 32'(a_err), 0);
      tick();
      a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 12'h020; a_ps = 1; a_rs = 0;
      tick();
      check("a_rd20_ack", 32'(a_ack), 1);
      check("a_rd20_dout", 32'(a_dout), 32'h0F0F);
      a_cyc = 0; a_stb = 0;
      tick();
      check("a_idle_ack", 32'(a_ack), 0);

      // WS=3: preload, then read with stall/latency check
      b_txn(1, 12'h200, 16'h0200, 1, 0, stalls, lat, ack_seen, err_seen);
      check("b_wr200_ack", 32'(ack_seen), 1);
      check("b_wr200_stalls", stalls, 3);
      b_txn(1, 12'h123, 16'h7777, 1, 0, stalls, lat, ack_seen, err_seen);
      check("b_wr123_ack", 32'(ack_seen), 1);
      check("b_wr_dout_hold", 32'(b_dout), 0);
      b_txn(0, 12'h123, 16'h0000, 0, 1, stalls, lat, ack_seen, err_seen);
      check("b_rd123_ack", 32'(ack_seen), 1);
      check("b_rd123_err", 32'(err_seen), 0);
      check("b_rd123_stalls", stalls, 3);
      check("b_rd123_lat", lat, 4);
      check("b_rd123_dout", 32'(b_dout), 32'h7777);

      // WS=3: cyc dropped in BUSY discards the response, write persists
      b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 12'h030; b_din = 16'h5555; b_ps = 1; b_rs = 0;
      tick();
      check("b_abort_stall", 32'(b_stall), 1);
      b_cyc = 0; b_stb = 0;
      tick();
      check("b_abort_idle", 32'(b_stall), 0);
      ack_seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (b_ack || b_err) ack_seen = 1;
         tick();
      end
      check("b_abort_no_resp", 32'(ack_seen), 0);
      b_txn(0, 12'h030, 16'h0000, 1, 0, stalls, lat, ack_seen, err_seen);
      check("b_rd030_ack", 32'(ack_seen), 1);
      check("b_rd030_dout", 32'(b_dout), 32'h5555);
      b_txn(0, 12'h200, 16'h0000, 1, 0, stalls, lat, ack_seen, err_seen);
      check("b_no_decoy", 32'(b_dout), 32'h0200);

      // WS=3: illegal tag after wait states
      b_txn(0, 12'h123, 16'h0000, 0, 0, stalls, lat, ack_seen, err_seen);
      check("b_ill_err", 32'(err_seen), 1);
      check("b_ill_ack", 32'(ack_seen), 0);
      check("b_ill_lat", lat, 4);

      // WS=3: asynchronous reset in BUSY
      b_cyc = 1; b_stb = 1; b_we = 0; b_adr = 12'h123; b_ps = 1; b_rs = 0;
      tick();
      check("b_pre_rst_stall", 32'(b_stall), 1);
      b_stb = 0; b_cyc = 0;
      rst_n = 0;
      #1;
      check("b_rst_stall", 32'(b_stall), 0);
      check("b_rst_ack", 32'(b_ack), 0);
      check("b_rst_err", 32'(b_err), 0);
      check("b_rst_dout", 32'(b_dout), 0);
      #2 rst_n = 1;
      tick();
      b_txn(0, 12'h123, 16'h0000, 1, 0, stalls, lat, ack_seen, err_seen);
      check("b_post_rst_ack", 32'(ack_seen), 1);
      check("b_post_rst_dout", 32'(b_dout), 32'h7777);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
